// File: rtl/multicycle_control_unit_if.sv
// Datapath / data-memory handshake bundle for the multicycle control unit.
//   opcode      : instr[6:0] from the datapath
//   dm_ready    : data memory access complete
//   fetch       : datapath fetch strobe
//   decode      : datapath decode strobe
//   rf_write_en : register file write strobe
//   dm_write_en : data memory write request
//   dm_read_en  : data memory read request
//   finished    : one-cycle retire pulse (datapath advances pc)
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if;
  logic [6:0] opcode;
  logic       dm_ready;
  logic       fetch;
  logic       decode;
  logic       rf_write_en;
  logic       dm_write_en;
  logic       dm_read_en;
  logic       finished;

  modport master (
    input  opcode, dm_ready,
    output fetch, decode, rf_write_en, dm_write_en, dm_read_en, finished
  );

  modport slave (
    output opcode, dm_ready,
    input  fetch, decode, rf_write_en, dm_write_en, dm_read_en, finished
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the single-issue RV64 datapath.
// Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK/RETIRE,
// waits on dm_ready in MEM (bounded by MEM_TIMEOUT), halts on SYSTEM,
// illegal opcode or memory timeout, and counts retired instructions.
// Ports:
//   clk, reset_n     : clock (rising edge), async active-low reset
//   start, stop      : leave IDLE / return to IDLE after the next retire
//   dp               : datapath + data memory handshake (master side)
//   halted           : core stopped in HALT
//   illegal          : sticky, halt cause was an illegal opcode
//   mem_timeout      : sticky, halt cause was a MEM timeout
//   state            : current state encoding (debug)
//   instr_count      : retired instruction count (wraps)
module multicycle_control_unit #(
  parameter int COUNT_WIDTH = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  multicycle_control_unit_if.master  dp,
  output logic                       halted,
  output logic                       illegal,
  output logic                       mem_timeout,
  output logic [2:0]                 state,
  output logic [COUNT_WIDTH-1:0]     instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_RETIRE    = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int         TW       = $clog2(MEM_TIMEOUT + 1);
  // Counter holds the number of MEM cycles already completed; the cycle
  // that would make it MEM_TIMEOUT is the last one allowed.
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  logic [2:0]    state_d;
  logic [6:0]    opcode_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode_q)
          OP_OP, OP_IMM, OP_JAL: state_d = S_WRITEBACK;
          OP_LOAD, OP_STORE:     state_d = S_MEM;
          OP_BRANCH:             state_d = S_RETIRE;
          default:               state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        // ready has priority over the timeout in the same cycle
        if (dp.dm_ready)  state_d = (opcode_q == OP_LOAD) ? S_WRITEBACK : S_RETIRE;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_WRITEBACK: state_d = S_RETIRE;
      S_RETIRE:    state_d = stop ? S_IDLE : S_FETCH;
      default:     state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      opcode_q    <= '0;
      tmo_cnt     <= '0;
      illegal     <= 1'b0;
      mem_timeout <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) opcode_q <= dp.opcode;
      if (state == S_EXECUTE)  tmo_cnt <= '0;
      else if (state == S_MEM) tmo_cnt <= tmo_cnt + TW'(1);
      if (state == S_EXECUTE && state_d == S_HALT && opcode_q != OP_SYSTEM)
        illegal <= 1'b1;
      if (state == S_MEM && state_d == S_HALT)
        mem_timeout <= 1'b1;
      if (state == S_RETIRE)
        instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

  // Moore outputs: state and opcode_q only, so strobes are glitch-free
  // and never follow inputs combinationally.
  always_comb begin
    dp.fetch       = (state == S_FETCH);
    dp.decode      = (state == S_DECODE);
    dp.rf_write_en = (state == S_WRITEBACK);
    dp.dm_read_en  = (state == S_MEM) && (opcode_q == OP_LOAD);
    dp.dm_write_en = (state == S_MEM) && (opcode_q == OP_STORE);
    dp.finished    = (state == S_RETIRE);
    halted         = (state == S_HALT);
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        halted;
  logic        illegal;
  logic        mem_timeout;
  logic [2:0]  state;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  multicycle_control_unit_if dp_if ();

  multicycle_control_unit #(.COUNT_WIDTH(32), .MEM_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .dp          (dp_if),
    .halted      (halted),
    .illegal     (illegal),
    .mem_timeout (mem_timeout),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {dp_if.fetch, dp_if.decode, dp_if.rf_write_en,
            dp_if.dm_write_en, dp_if.dm_read_en, dp_if.finished};
  endfunction

  // advance one clock, sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot", 64'($countones(strobes()) <= 1), 64'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int ret;
    int fin;
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    dp_if.opcode = 7'd0;
    dp_if.dm_ready = 1'b0;

    // ---------------- reset state
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_strobes", strobes(), 0);
    chk("rst_count", instr_count, 0);
    chk("rst_flags", {halted, illegal, mem_timeout}, 0);
    reset_n = 1'b1;
    step();
    chk("idle_hold", state, 0);

    // ---------------- OP instruction: 1,2,3,5,6,1
    start = 1'b1; dp_if.opcode = OP_OP;
    step(); start = 1'b0;
    chk("op_fetch_st", state, 1);
    chk("op_fetch", strobes(), 6'b100000);
    step(); chk("op_dec_st", state, 2); chk("op_dec", dp_if.decode, 1);
    step(); chk("op_ex_st", state, 3); chk("op_ex_strobes", strobes(), 0);
    step(); chk("op_wb_st", state, 5); chk("op_wb", strobes(), 6'b001000);
    step(); chk("op_ret_st", state, 6); chk("op_ret", strobes(), 6'b000001);
    chk("op_cnt_pre", instr_count, 0);
    dp_if.opcode = OP_LOAD;
    step(); chk("op_next_fetch", state, 1); chk("op_cnt", instr_count, 1);

    // ---------------- LOAD, ready in 4th MEM cycle
    step(); step();
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("ld_mem_st", state, 4);
      if (dp_if.dm_read_en) n++;
      chk("ld_no_wr", dp_if.dm_write_en, 0);
      if (i == 4) dp_if.dm_ready = 1'b1;
    end
    chk("ld_read_cycles", n, 4);
    step(); dp_if.dm_ready = 1'b0;
    chk("ld_wb_st", state, 5); chk("ld_wb", strobes(), 6'b001000);
    step(); chk("ld_ret_st", state, 6);
    dp_if.opcode = OP_STORE;
    step(); chk("ld_cnt", instr_count, 2);

    // ---------------- STORE, immediate ready
    step(); step();
    step(); chk("st_mem_st", state, 4); chk("st_mem", strobes(), 6'b000100);
    dp_if.dm_ready = 1'b1;
    step(); dp_if.dm_ready = 1'b0;
    chk("st_ret_st", state, 6); chk("st_ret_no_rf", strobes(), 6'b000001);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("st_idle", state, 0); chk("st_cnt", instr_count, 3);
    step(); chk("idle_stays", state, 0);

    // ---------------- 10 BRANCHes, stop in 10th RETIRE
    start = 1'b1; dp_if.opcode = OP_BRANCH;
    step(); start = 1'b0;
    n = 0; ret = 0;
    while (state != 3'd0 && n < 100) begin
      n++;
      if (state == 3'd6) begin
        ret++;
        if (ret == 10) stop = 1'b1;
      end
      step();
    end
    stop = 1'b0;
    chk("br_cycles", n, 40);
    chk("br_retires", ret, 10);
    chk("br_idle", state, 0);
    chk("br_cnt", instr_count, 13);

    // ---------------- STORE timeout
    start = 1'b1; dp_if.opcode = OP_STORE;
    step(); start = 1'b0;
    step(); step(); step();
    n = 0; fin = 0;
    while (state == 3'd4 && n < 40) begin
      if (dp_if.dm_write_en) n++;
      if (dp_if.finished) fin++;
      step();
    end
    chk("tmo_wr_cycles", n, 16);
    chk("tmo_finished", fin, 0);
    chk("tmo_state", state, 7);
    chk("tmo_flags", {halted, illegal, mem_timeout}, 3'b101);
    chk("tmo_strobes", strobes(), 0);
    chk("tmo_cnt", instr_count, 13);
    start = 1'b1; stop = 1'b1;
    step(); step();
    start = 1'b0; stop = 1'b0;
    chk("tmo_terminal", state, 7);

    // ---------------- illegal opcode
    do_reset();
    chk("rst2_flags", {halted, illegal, mem_timeout}, 0);
    chk("rst2_cnt", instr_count, 0);
    start = 1'b1; dp_if.opcode = OP_BAD;
    step(); start = 1'b0;
    step();
    step(); chk("ill_ex", state, 3); chk("ill_not_yet", illegal, 0);
    step(); chk("ill_state", state, 7);
    chk("ill_flags", {halted, illegal, mem_timeout}, 3'b110);
    start = 1'b1;
    step(); start = 1'b0;
    step(); chk("ill_terminal", state, 7);

    // ---------------- SYSTEM halt
    do_reset();
    start = 1'b1; dp_if.opcode = OP_SYSTEM;
    step(); start = 1'b0;
    step(); step(); step();
    chk("sys_state", state, 7);
    chk("sys_flags", {halted, illegal, mem_timeout}, 3'b100);
    start = 1'b1;
    step(); start = 1'b0;
    chk("sys_terminal", state, 7);

    // ---------------- async reset mid-MEM
    do_reset();
    start = 1'b1; dp_if.opcode = OP_OP;
    step(); start = 1'b0;
    step(); step(); step(); step();
    dp_if.opcode = OP_LOAD;
    step(); chk("ar_cnt_pre", instr_count, 1);
    step(); step(); step();
    chk("ar_mem", strobes(), 6'b000010);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_state", state, 0);
    chk("ar_strobes", strobes(), 0);
    chk("ar_cnt", instr_count, 0);
    chk("ar_flags", {halted, illegal, mem_timeout}, 0);
    step(); reset_n = 1'b1;
    step(); chk("ar_idle", state, 0);
    start = 1'b1; dp_if.opcode = OP_OP;
    step(); start = 1'b0;
    chk("ar2_fetch", state, 1);
    step(); step(); step();
    chk("ar2_wb", state, 5);
    step(); chk("ar2_ret", state, 6);
    stop = 1'b1;
    step(); stop = 1'b0;
    chk("ar2_idle", state, 0);
    chk("ar2_cnt", instr_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
